nibble_operand_packer: RTL and testbench

- Upstream feeder for the 64-bit FSM datapath stage.
- Accepts paired N_width-bit operand chunks, LSB chunk first, over a valid/ready handshake.
- Assembles each run of chunks into full N-bit a and b words and presents them downstream over a second valid/ready handshake.
- Two-deep buffering (assembly register plus holding register) lets the next word fill while the previous word waits for the consumer.

---
 rtl/nibble_operand_packer.sv | 114 +++++++++++
 tb/tb_nibble_operand_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_operand_packer.sv
// Assembles LSB-first N_width-bit a/b chunks into N-bit operand pairs with an
// assembly register plus a holding register. Define PACKER_PARITY_EN for out_parity.
module nibble_operand_packer #(
  parameter  int N       = 64,
  parameter  int N_width = 4,
  localparam int BEATS   = N / N_width,
  localparam int CW      = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_width-1:0] a_in,
  input  logic [N_width-1:0] b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       a_word,
  output logic [N-1:0]       b_word,
  output logic [CW-1:0]      beat_count,
  output logic [1:0]         out_parity
);

  localparam logic [0:0] ASM_FILLING = 1'b0;
  localparam logic [0:0] ASM_FULL    = 1'b1;
  localparam logic [0:0] HOLD_EMPTY  = 1'b0;
  localparam logic [0:0] HOLD_VALID  = 1'b1;

  logic [0:0]   asm_state;
  logic [0:0]   hold_state;
  logic [N-1:0] asm_a, asm_b;
  logic [N-1:0] hold_a, hold_b;
  logic [N-1:0] merged_a, merged_b;
  logic [N-1:0] src_a, src_b;
  logic         chunk_accept;
  logic         word_accept;
  logic         last_beat;
  logic         load_hold;

  // in_ready is gated by rst so no chunk is offered acceptance during reset.
  assign in_ready     = rst & (asm_state == ASM_FILLING);
  assign out_valid    = (hold_state == HOLD_VALID);
  assign chunk_accept = in_valid & in_ready & ~clear;
  assign word_accept  = out_valid & out_ready;
  assign last_beat    = chunk_accept & (beat_count == CW'(BEATS - 1));

  // A completed word moves to hold if hold is free or being drained this cycle.
  assign load_hold = ~clear & ((last_beat & (~out_valid | out_ready)) |
                               ((asm_state == ASM_FULL) & word_accept));

  // NOTE: full default before the partial overwrite keeps this purely combinational (no latch).
  always_comb begin
    merged_a = asm_a;
    merged_b = asm_b;
    merged_a[beat_count * N_width +: N_width] = a_in;
    merged_b[beat_count * N_width +: N_width] = b_in;
  end

  // In FULL the stored word is complete; otherwise the incoming last chunk is merged in.
  assign src_a = (asm_state == ASM_FULL) ? asm_a : merged_a;
  assign src_b = (asm_state == ASM_FULL) ? asm_b : merged_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_state  <= ASM_FILLING;
      beat_count <= '0;
      asm_a      <= '0;
      asm_b      <= '0;
    end else if (clear) begin
      asm_state  <= ASM_FILLING;
      beat_count <= '0;
      asm_a      <= '0;
      asm_b      <= '0;
    end else if (load_hold) begin
      asm_state  <= ASM_FILLING;
      beat_count <= '0;
      asm_a      <= '0;
      asm_b      <= '0;
    end else if (last_beat) begin
      asm_state  <= ASM_FULL;
      beat_count <= '0;
      asm_a      <= merged_a;
      asm_b      <= merged_b;
    end else if (chunk_accept) begin
      beat_count <= beat_count + 1'b1;
      asm_a      <= merged_a;
      asm_b      <= merged_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_state <= HOLD_EMPTY;
      hold_a     <= '0;
      hold_b     <= '0;
    end else if (load_hold) begin
      hold_state <= HOLD_VALID;
      hold_a     <= src_a;
      hold_b     <= src_b;
    end else if (word_accept) begin
      hold_state <= HOLD_EMPTY;
    end
  end

  assign a_word = hold_a;
  assign b_word = hold_b;

`ifdef PACKER_PARITY_EN
  assign out_parity = out_valid ? {^hold_b, ^hold_a} : 2'b00;
`else
  assign out_parity = 2'b00;
`endif

endmodule

// File: tb/tb_nibble_operand_packer.sv
// Directed bench for nibble_operand_packer: expected pairs go into a queue and a
// negedge monitor pops and compares each word the consumer accepts.
module tb_nibble_operand_packer;

  localparam int N  = 64;
  localparam int NW = 4;
  localparam int CW = 4;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pair_t;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] a_in;
  logic [NW-1:0] b_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  a_word;
  logic [N-1:0]  b_word;
  logic [CW-1:0] beat_count;
  logic [1:0]    out_parity;

  pair_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  bit    track = 0;
  int    tr_cyc = 0;
  int    tr_drops = 0;
  int    tr_valid[$];

  nibble_operand_packer #(.N(N), .N_width(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_word     (a_word),
    .b_word     (b_word),
    .beat_count (beat_count),
    .out_parity (out_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    exp_q.push_back(p);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [NW-1:0] a, input logic [NW-1:0] b);
    int waited = 0;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a word is consumed on the next posedge when valid&ready here.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got a=%h b=%h with empty queue", a_word, b_word);
      end else begin
        pair_t p;
        p = exp_q.pop_front();
        check("sb_a_word", a_word, p.a);
        check("sb_b_word", b_word, p.b);
      end
    end
  end

  always @(negedge clk) begin
    if (track) begin
      if (!in_ready) tr_drops++;
      if (out_valid) tr_valid.push_back(tr_cyc);
      tr_cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_par;
`ifdef PACKER_PARITY_EN
    exp_par = 2'b01;
`else
    exp_par = 2'b00;
`endif
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_a_word", a_word, 64'd0);
    check("rst_b_word", b_word, 64'd0);
    check("rst_beat_count", 64'(beat_count), 64'd0);
    check("rst_parity", 64'(out_parity), 64'd0);
    rst = 1'b1;
    step();

    // 1: ascending / descending chunks, one-cycle latency
    out_ready = 1'b1;
    push(64'hFEDCBA9876543210, 64'h0123456789ABCDEF);
    for (int k = 0; k < 15; k++) send(NW'(k), NW'(15 - k));
    check("t1_no_early_valid", 64'(out_valid), 64'd0);
    check("t1_beat_count_15", 64'(beat_count), 64'd15);
    send(4'd15, 4'd0);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_a_word", a_word, 64'hFEDCBA9876543210);
    check("t1_b_word", b_word, 64'h0123456789ABCDEF);
    check("t1_beat_count", 64'(beat_count), 64'd0);
    step();
    check("t1_drained", 64'(out_valid), 64'd0);

    // 2: back-pressure fills both registers then stalls
    out_ready = 1'b0;
    push(64'h1111111111111111, 64'h2222222222222222);
    push(64'h1111111111111111, 64'h2222222222222222);
    for (int k = 0; k < 32; k++) send(4'd1, 4'd2);
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    in_valid = 1'b1; a_in = 4'd1; b_in = 4'd2;
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_in_ready", 64'(in_ready), 64'd0);
      check("t2_stall_a_word", a_word, 64'h1111111111111111);
    end
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t2_word2_valid", 64'(out_valid), 64'd1);
    check("t2_word2_a", a_word, 64'h1111111111111111);
    check("t2_word2_b", b_word, 64'h2222222222222222);
    check("t2_in_ready_back", 64'(in_ready), 64'd1);
    for (int k = 0; k < 8; k++) send(4'd1, 4'd2);
    check("t2_beat_count_8", 64'(beat_count), 64'd8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t2_clear_beats", 64'(beat_count), 64'd0);
    check("t2_clear_keeps_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("t2_drained", 64'(out_valid), 64'd0);

    // 3: clear together with a valid beat drops it and wipes the partial word
    for (int k = 0; k < 5; k++) send(4'hF, 4'hF);
    check("t3_beat_count_5", 64'(beat_count), 64'd5);
    in_valid = 1'b1; a_in = 4'hF; b_in = 4'hF; clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("t3_clear_beats", 64'(beat_count), 64'd0);
    push(64'h3333333333333333, 64'h3333333333333333);
    for (int k = 0; k < 16; k++) send(4'h3, 4'h3);
    check("t3_a_word", a_word, 64'h3333333333333333);
    step();

    // 4: 48 back-to-back beats, no bubbles
    push(64'h4444444444444444, 64'h7777777777777777);
    push(64'h5555555555555555, 64'h8888888888888888);
    push(64'h6666666666666666, 64'h9999999999999999);
    track = 1'b1;
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 16; k++) send(NW'(4 + w), NW'(7 + w));
    @(negedge clk);
    #1 track = 1'b0;
    check("t4_cycles", 64'(tr_cyc), 64'd49);
    check("t4_in_ready_drops", 64'(tr_drops), 64'd0);
    check("t4_valid_pulses", 64'(tr_valid.size()), 64'd3);
    if (tr_valid.size() == 3) begin
      check("t4_pulse0", 64'(tr_valid[0]), 64'd16);
      check("t4_pulse1", 64'(tr_valid[1]), 64'd32);
      check("t4_pulse2", 64'(tr_valid[2]), 64'd48);
    end
    step();

    // 5: asynchronous reset with a word held and a partial word in flight
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(4'hC, 4'hD);
    for (int k = 0; k < 9; k++) send(4'hE, 4'hB);
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    check("t5_pre_beats", 64'(beat_count), 64'd9);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_a_word", a_word, 64'd0);
    check("t5_rst_b_word", b_word, 64'd0);
    check("t5_rst_beats", 64'(beat_count), 64'd0);
    check("t5_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst = 1'b1;
    step();
    out_ready = 1'b1;
    push(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555);
    for (int k = 0; k < 16; k++) send(4'hA, 4'h5);
    check("t5_fresh_valid", 64'(out_valid), 64'd1);
    step();

    // 6: parity of the held word
    out_ready = 1'b0;
    push(64'h1, 64'h3);
    send(4'h1, 4'h3);
    for (int k = 0; k < 15; k++) send(4'h0, 4'h0);
    check("t6_a_word", a_word, 64'h1);
    check("t6_parity", 64'(out_parity), 64'(exp_par));
    out_ready = 1'b1;
    step();
    check("t6_drained", 64'(out_valid), 64'd0);
    check("t6_parity_idle", 64'(out_parity), 64'd0);

    repeat (2) step();
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
